// File: rtl/regfile_read_port_if.sv
// Request/response handshake bundle for the register file read port.
// master = decode/issue side, slave = the read port itself.
interface regfile_read_port_if #(
  parameter int ADDR_WIDTH = 4,
  parameter int DATA_WIDTH = 32
);
  logic                  req_vld;
  logic                  req_rdy;
  logic [ADDR_WIDTH-1:0] addr0;
  logic [ADDR_WIDTH-1:0] addr1;
  logic                  rsp_vld;
  logic                  rsp_rdy;
  logic [DATA_WIDTH-1:0] data0;
  logic [DATA_WIDTH-1:0] data1;

  modport master (
    output req_vld, addr0, addr1, rsp_rdy,
    input  req_rdy, rsp_vld, data0, data1
  );

  modport slave (
    input  req_vld, addr0, addr1, rsp_rdy,
    output req_rdy, rsp_vld, data0, data1
  );
endinterface

// File: rtl/regfile_read_port.sv
// Dual operand read port with registered valid/ready output and skid entry.
// Define REGFILE_RD_BYPASS_EN to forward same-edge register file writes.
module regfile_read_port #(
  parameter int ADDR_WIDTH = 4,
  parameter int DATA_WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic [2**ADDR_WIDTH-1:1][DATA_WIDTH-1:0] mem,
  input  logic                  wr_en,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  regfile_read_port_if.slave    rd
);

  typedef enum logic [1:0] {
    EMPTY = 2'b00,
    FULL1 = 2'b01,
    FULL2 = 2'b11
  } state_t;

  state_t                state;
  logic                  rdy;
  logic [DATA_WIDTH-1:0] main0;
  logic [DATA_WIDTH-1:0] main1;
  logic [DATA_WIDTH-1:0] skid0;
  logic [DATA_WIDTH-1:0] skid1;
  logic [DATA_WIDTH-1:0] op0;
  logic [DATA_WIDTH-1:0] op1;
  logic                  accept;
  logic                  deliver;

`ifndef REGFILE_RD_BYPASS_EN
  logic unused_wr;
  assign unused_wr = ^{wr_en, wr_addr, wr_data};
`endif

  function automatic logic [DATA_WIDTH-1:0] pick(
    input logic [ADDR_WIDTH-1:0] a
  );
    logic [DATA_WIDTH-1:0] v;
    v = '0;
    if (a == '0) begin
      v = '0;
`ifdef REGFILE_RD_BYPASS_EN
    end else if (wr_en && (wr_addr == a)) begin
      v = wr_data;
`endif
    end else begin
      v = mem[a];
    end
    return v;
  endfunction

  assign op0     = pick(rd.addr0);
  assign op1     = pick(rd.addr1);
  assign accept  = rd.req_vld & rdy;
  assign deliver = state[0] & rd.rsp_rdy;

  assign rd.req_rdy = rdy;
  assign rd.rsp_vld = state[0];
  assign rd.data0   = main0;
  assign rd.data1   = main1;

  // rdy mirrors ~skid valid but is its own flop, so no path from rsp_rdy
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state <= EMPTY;
      rdy   <= 1'b1;
      main0 <= '0;
      main1 <= '0;
      skid0 <= '0;
      skid1 <= '0;
    end else begin
      unique case (state)
        EMPTY: begin
          if (accept) begin
            main0 <= op0;
            main1 <= op1;
            state <= FULL1;
          end
        end
        FULL1: begin
          if (accept && !deliver) begin
            skid0 <= op0;
            skid1 <= op1;
            state <= FULL2;
            rdy   <= 1'b0;
          end else if (accept) begin
            main0 <= op0;
            main1 <= op1;
          end else if (deliver) begin
            state <= EMPTY;
          end
        end
        FULL2: begin
          if (deliver) begin
            main0 <= skid0;
            main1 <= skid1;
            skid0 <= '0;
            skid1 <= '0;
            state <= FULL1;
            rdy   <= 1'b1;
          end
        end
        default: begin
          state <= EMPTY;
          rdy   <= 1'b1;
        end
      endcase
    end
  end

endmodule
